// File: rtl/mem_req_queue_if.sv
// Host-side request/response channel of the memory request queue.
// The host pushes commands with valid/ready and receives one response pulse per issued command.
interface mem_req_queue_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_we;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_we, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_we, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_req_queue.sv
// Request FIFO plus single-outstanding command issuer in front of the memory controller.
// Each popped command yields exactly one response: read data, write ack, or timeout error.
module mem_req_queue #(
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  mem_req_queue_if.slave           host,
  output logic                     cmd_valid_sys,
  output logic                     we_sys,
  output logic [AW-1:0]            addr_sys,
  inout  wire  [DW-1:0]            data_sys,
  input  logic                     ready_sys,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [1:0]      state;
  logic [TW-1:0]   timer;
  entry_t          cmd_q;
  logic            full;
  logic            push;
  logic            pop;

  // Full blocks a push even when a pop frees a slot in the same cycle.
  assign full = (count == CW'(DEPTH));
  assign push = host.req_valid && !full;
  assign pop  = (state == S_IDLE) && (count != '0);

  assign host.req_ready = !full;
  assign fifo_count     = count;
  assign busy           = (state != S_IDLE) || (count != '0);
  assign we_sys         = cmd_q.we;
  assign addr_sys       = cmd_q.addr;
  assign data_sys       = (state == S_ISSUE && cmd_q.we) ? cmd_q.wdata : 'z;

  // NOTE: storage has no reset; validity is tracked by the pointers and count alone.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr] <= '{we: host.req_we, addr: host.req_addr, wdata: host.req_wdata};
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= S_IDLE;
      timer          <= '0;
      cmd_q          <= '0;
      cmd_valid_sys  <= 1'b0;
      host.rsp_valid <= 1'b0;
      host.rsp_we    <= 1'b0;
      host.rsp_rdata <= '0;
      host.rsp_err   <= 1'b0;
    end else begin
      host.rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pop) begin
            cmd_q         <= mem_q[rd_ptr];
            cmd_valid_sys <= 1'b1;
            timer         <= '0;
            state         <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (ready_sys) begin
            host.rsp_valid <= 1'b1;
            host.rsp_we    <= cmd_q.we;
            host.rsp_rdata <= cmd_q.we ? '0 : data_sys;
            host.rsp_err   <= 1'b0;
            cmd_valid_sys  <= 1'b0;
            state          <= S_RELEASE;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            host.rsp_valid <= 1'b1;
            host.rsp_we    <= cmd_q.we;
            host.rsp_rdata <= '0;
            host.rsp_err   <= 1'b1;
            cmd_valid_sys  <= 1'b0;
            state          <= S_RELEASE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_RELEASE: begin
          // A controller still holding ready from the finished command must not complete the next one.
          if (!ready_sys) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_req_queue.sv
// Self-checking bench for mem_req_queue: directed scenarios plus random traffic,
// compared every cycle against a transaction-level queue/memory reference model.
module tb_mem_req_queue;
  localparam int AW = 8, DW = 8, DEPTH = 4, TIMEOUT = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mem_req_queue_if #(.AW(AW), .DW(DW)) host_if ();
  logic                   cmd_valid_sys, we_sys;
  logic                   ready_sys = 1'b0;
  logic [AW-1:0]          addr_sys;
  wire  [DW-1:0]          data_sys;
  logic [DW-1:0]          tb_bus = '0;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   busy;

  // The controller side owns the bus whenever the DUT is not presenting write data.
  assign data_sys = (cmd_valid_sys && we_sys) ? 'z : tb_bus;

  mem_req_queue #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .host(host_if),
    .cmd_valid_sys(cmd_valid_sys), .we_sys(we_sys), .addr_sys(addr_sys),
    .data_sys(data_sys), .ready_sys(ready_sys),
    .fifo_count(fifo_count), .busy(busy)
  );

  int total = 0, bad = 0, cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata; } req_t;
  typedef enum { M_FREE, M_BUSY, M_DRAIN } phase_t;
  req_t          mq[$];
  req_t          cur;
  phase_t        phase = M_FREE;
  int            issued_at = 0;
  logic [DW-1:0] model_mem [256];
  logic          exp_rsp_valid = 0, exp_rsp_we = 0, exp_rsp_err = 0;
  logic [DW-1:0] exp_rsp_rdata = '0;
  bit            last_pushed = 0;

  // Advances the model across the rising edge using the inputs that were present before it.
  task automatic model_edge();
    bit can_push;
    can_push = host_if.req_valid && (mq.size() < DEPTH);
    exp_rsp_valid = 0;
    case (phase)
      M_FREE: if (mq.size() > 0) begin
        cur = mq.pop_front();
        issued_at = cyc;
        phase = M_BUSY;
      end
      M_BUSY: if (ready_sys) begin
        exp_rsp_valid = 1; exp_rsp_we = cur.we; exp_rsp_err = 0;
        exp_rsp_rdata = cur.we ? '0 : model_mem[cur.addr];
        if (cur.we) model_mem[cur.addr] = cur.wdata;
        phase = M_DRAIN;
      end else if (cyc - issued_at == TIMEOUT) begin
        exp_rsp_valid = 1; exp_rsp_we = cur.we; exp_rsp_err = 1; exp_rsp_rdata = '0;
        phase = M_DRAIN;
      end
      M_DRAIN: if (!ready_sys) phase = M_FREE;
      default: phase = M_FREE;
    endcase
    last_pushed = can_push;
    if (can_push) mq.push_back('{we: host_if.req_we, addr: host_if.req_addr, wdata: host_if.req_wdata});
  endtask

  task automatic compare_all();
    check("cmd_valid", cmd_valid_sys, phase == M_BUSY);
    check("req_ready", host_if.req_ready, mq.size() < DEPTH);
    check("fifo_count", fifo_count, mq.size());
    check("busy", busy, (phase != M_FREE) || (mq.size() != 0));
    check("rsp_valid", host_if.rsp_valid, exp_rsp_valid);
    if (exp_rsp_valid) begin
      check("rsp_we", host_if.rsp_we, exp_rsp_we);
      check("rsp_err", host_if.rsp_err, exp_rsp_err);
      check("rsp_rdata", host_if.rsp_rdata, exp_rsp_rdata);
    end
    if (phase == M_BUSY) begin
      check("we_sys", we_sys, cur.we);
      check("addr_sys", addr_sys, cur.addr);
    end
    if (phase == M_BUSY && cur.we) check("data_sys_wr", data_sys, cur.wdata);
    else                           check("data_sys_released", data_sys, tb_bus);
  endtask

  // ---------------- controller stimulus ----------------
  logic [DW-1:0] ctl_mem [256];
  int wait_cnt = 0, delay = 1, stale_left = 0, next_stale = 0;
  int dly_lo = 1, dly_hi = 1, stl_lo = 0, stl_hi = 0;

  task automatic ctl_drive();
    if (ready_sys) begin
      if (!cmd_valid_sys) begin
        if (stale_left > 0) stale_left--;
        else ready_sys = 1'b0;
      end
    end else if (cmd_valid_sys) begin
      if (wait_cnt == 0) begin
        delay      = $urandom_range(dly_hi, dly_lo);
        next_stale = $urandom_range(stl_hi, stl_lo);
      end
      wait_cnt++;
      if (wait_cnt >= delay) begin
        ready_sys  = 1'b1;
        stale_left = next_stale;
        if (we_sys) ctl_mem[addr_sys] = data_sys;
        else        tb_bus = ctl_mem[addr_sys];
      end
    end else begin
      wait_cnt = 0;
    end
    if (!ready_sys) tb_bus = DW'($urandom);
  endtask

  // ---------------- cycle driver and observations ----------------
  logic prev_cv = 0, saw_full = 0;
  logic [DW-1:0] seen_rdata = '0;
  int rise_cyc = 0, last_lat = 0;

  task automatic cycle();
    @(negedge clk);
    cyc++;
    model_edge();
    compare_all();
    if (cmd_valid_sys && !prev_cv) rise_cyc = cyc;
    if (host_if.rsp_valid) begin
      last_lat   = cyc - rise_cyc;
      seen_rdata = host_if.rsp_rdata;
    end
    if (!host_if.req_ready && fifo_count == DEPTH) saw_full = 1;
    prev_cv = cmd_valid_sys;
    ctl_drive();
  endtask

  task automatic push_req(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    bit done = 0;
    host_if.req_valid = 1'b1;
    host_if.req_we    = we;
    host_if.req_addr  = addr;
    host_if.req_wdata = wdata;
    for (int i = 0; i < 500 && !done; i++) begin
      cycle();
      done = last_pushed;
    end
    if (!done) check("push_timeout", 0, 1);
    host_if.req_valid = 1'b0;
  endtask

  task automatic drain();
    bit done = 0;
    for (int i = 0; i < 3000 && !done; i++) begin
      cycle();
      done = (phase == M_FREE) && (mq.size() == 0) && !ready_sys;
    end
    if (!done) check("drain_timeout", 0, 1);
  endtask

  task automatic set_ctl(input int dl, input int dh, input int sl, input int sh);
    dly_lo = dl; dly_hi = dh; stl_lo = sl; stl_hi = sh;
  endtask

  initial begin
    for (int a = 0; a < 256; a++) begin
      model_mem[a] = '0;
      ctl_mem[a]   = '0;
    end
    host_if.req_valid = 1'b0;
    host_if.req_we    = 1'b0;
    host_if.req_addr  = '0;
    host_if.req_wdata = '0;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_cmd_valid", cmd_valid_sys, 0);
    check("rst_rsp_valid", host_if.rsp_valid, 0);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_req_ready", host_if.req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_we_addr", {we_sys, addr_sys}, 0);
    check("rst_rsp_rdata", host_if.rsp_rdata, 0);
    check("rst_data_sys", data_sys, tb_bus);
    reset = 1'b1;

    // Single write, then read back through the controller memory
    set_ctl(3, 3, 0, 0);
    push_req(1'b1, 8'h10, 8'h3C);
    drain();
    push_req(1'b0, 8'h10, 8'h00);
    drain();
    check("t2_read_back", seen_rdata, 8'h3C);

    // Fill with a stuck controller: every command times out
    set_ctl(100, 100, 0, 0);
    for (int i = 0; i < 6; i++) push_req(i[0], 8'(8'h20 + i), 8'(8'h50 + i));
    check("t3_saw_full", saw_full, 1);
    drain();
    check("t4_timeout_latency", last_lat, TIMEOUT);

    // Stale ready held after each completion
    set_ctl(2, 2, 3, 3);
    push_req(1'b1, 8'h30, 8'hA1);
    push_req(1'b1, 8'h31, 8'hA2);
    push_req(1'b0, 8'h30, 8'h00);
    drain();
    check("t5_stale_read", seen_rdata, 8'hA1);

    // Asynchronous reset in the middle of a write command
    set_ctl(100, 100, 0, 0);
    push_req(1'b1, 8'h40, 8'h77);
    push_req(1'b0, 8'h41, 8'h00);
    push_req(1'b1, 8'h42, 8'h11);
    cycle();
    cycle();
    check("t6_pre_in_issue", cmd_valid_sys, 1);
    #2 reset = 1'b0;
    #1;
    check("t6_cmd_valid", cmd_valid_sys, 0);
    check("t6_fifo_count", fifo_count, 0);
    check("t6_rsp_valid", host_if.rsp_valid, 0);
    check("t6_data_sys", data_sys, tb_bus);
    check("t6_busy", busy, 0);
    mq.delete();
    phase = M_FREE;
    exp_rsp_valid = 0;
    ready_sys = 1'b0;
    wait_cnt = 0;
    prev_cv = 0;
    #1 reset = 1'b1;

    // Random traffic: short and long controller delays, random stale-ready tails
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(9, 0) == 0) set_ctl(14, 18, 0, 3);
      else                           set_ctl(1, 6, 0, 3);
      host_if.req_valid = ($urandom_range(9, 0) < 6);
      host_if.req_we    = $urandom_range(1, 0) == 1;
      host_if.req_addr  = AW'($urandom_range(7, 0));
      host_if.req_wdata = DW'($urandom);
      cycle();
    end
    host_if.req_valid = 1'b0;
    set_ctl(1, 3, 0, 2);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
